// File: rtl/mul_pkg.sv
// mul_pkg: shared decode constants, state and sign-mode encodings, and small
// arithmetic helpers for the M-extension multiply sequencer.
//   OPCODE_OP / FUNCT7_MULDIV / F3_*  : instruction decode constants
//   state_e                           : sequencer FSM states
//   sign_mode_e                       : {rs1 signed, rs2 signed}
package mul_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    FIX   = 3'd3,
    RESP  = 3'd4,
    DRAIN = 3'd5
  } state_e;

  // Bit 1: rs1 treated as signed, bit 0: rs2 treated as signed.
  typedef enum logic [1:0] {
    SM_UU = 2'b00,
    SM_US = 2'b01,
    SM_SU = 2'b10,
    SM_SS = 2'b11
  } sign_mode_e;

  function automatic logic is_legal_mul(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic [6:0] funct7);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && (funct3[2] == 1'b0);
  endfunction

  function automatic sign_mode_e sign_mode_of(input logic [2:0] funct3);
    sign_mode_e m;
    case (funct3)
      F3_MUL, F3_MULH: m = SM_SS;
      F3_MULHSU:       m = SM_SU;
      default:         m = SM_UU;
    endcase
    return m;
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  function automatic logic [31:0] select_word(input logic [63:0] p, input logic [2:0] funct3);
    return (funct3 == F3_MUL) ? p[31:0] : p[63:32];
  endfunction

endpackage

// File: rtl/mul_product_cache.sv
// mul_product_cache: one-entry store of the last sign-corrected 64-bit product.
//   clk_i, rst_ni           : clock, synchronous active-low reset (invalidates)
//   lk_*_i                  : lookup key of the op being accepted
//   hit_o, product_o        : hit flag and stored product
//   wr_en_i, wr_*_i         : write a new key/product and mark valid
module mul_product_cache
  import mul_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] lk_rs1_i,
  input  logic [31:0] lk_rs2_i,
  input  logic [7:0]  lk_acc_i,
  input  sign_mode_e  lk_mode_i,
  input  logic [2:0]  lk_funct3_i,
  output logic        hit_o,
  output logic [63:0] product_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_rs1_i,
  input  logic [31:0] wr_rs2_i,
  input  logic [7:0]  wr_acc_i,
  input  sign_mode_e  wr_mode_i,
  input  logic [63:0] wr_product_i
);

  logic        valid_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [7:0]  acc_q;
  sign_mode_e  mode_q;
  logic [63:0] product_q;
  logic        key_match_s;
  logic        mode_ok_s;

  // Capture key and product of each completed core run.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      rs1_q     <= 32'd0;
      rs2_q     <= 32'd0;
      acc_q     <= 8'd0;
      mode_q    <= SM_UU;
      product_q <= 64'd0;
    end else if (wr_en_i) begin
      valid_q   <= 1'b1;
      rs1_q     <= wr_rs1_i;
      rs2_q     <= wr_rs2_i;
      acc_q     <= wr_acc_i;
      mode_q    <= wr_mode_i;
      product_q <= wr_product_i;
    end
  end

  // The MUL low word is the same for every signedness, so MUL may reuse a
  // product computed under a different sign mode.
  always_comb begin
    key_match_s = (lk_rs1_i == rs1_q) && (lk_rs2_i == rs2_q) && (lk_acc_i == acc_q);
    mode_ok_s   = (lk_mode_i == mode_q) || (lk_funct3_i == F3_MUL);
    if (ENABLE) begin
      hit_o = valid_q && key_match_s && mode_ok_s;
    end else begin
      hit_o = 1'b0;
    end
  end

  assign product_o = product_q;

endmodule

// File: rtl/multiplier_sequencer.sv
// multiplier_sequencer: sequences MUL/MULH/MULHSU/MULHU onto an unsigned
// multi-cycle 32x32->64 core, with sign correction and a one-entry cache.
//   CLK, reset_n                      : clock, synchronous active-low reset
//   req_valid/opcode/funct3/funct7    : op presented by decode
//   rs1, rs2, accuracy_level          : operands and CSR accuracy
//   flush                             : kill the in-flight op
//   req_ready, mul_unit_busy          : IDLE indication / pipeline stall
//   resp_valid, mul_output            : result pulse and held result word
//   core_start/core_in_*/core_accuracy: core request
//   core_busy, core_result            : core status and unsigned product
module multiplier_sequencer
  import mul_pkg::*;
#(
  parameter bit ACCURACY = 1'b0,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [7:0]  accuracy_level,
  input  logic        flush,
  output logic        req_ready,
  output logic        mul_unit_busy,
  output logic        resp_valid,
  output logic [31:0] mul_output,
  output logic        core_start,
  output logic [31:0] core_in_1,
  output logic [31:0] core_in_2,
  output logic [7:0]  core_accuracy,
  input  logic        core_busy,
  input  logic [63:0] core_result
);

  state_e      state_q;
  logic [31:0] key_rs1_q;
  logic [31:0] key_rs2_q;
  logic [7:0]  key_acc_q;
  sign_mode_e  mode_q;
  logic [2:0]  funct3_q;
  logic        neg_q;
  logic [63:0] cres_q;
  logic        core_start_q;
  logic [31:0] core_in_1_q;
  logic [31:0] core_in_2_q;
  logic [7:0]  core_accuracy_q;
  logic        resp_valid_q;
  logic [31:0] out_new_q;
  logic [31:0] out_hold_q;

  logic        accept_s;
  logic [7:0]  acc_eff_s;
  sign_mode_e  mode_s;
  logic [1:0]  mode_bits_s;
  logic        neg_s;
  logic [31:0] mag1_s;
  logic [31:0] mag2_s;
  logic [63:0] fixed_product_s;
  logic        cache_hit_s;
  logic [63:0] cache_product_s;
  logic        fix_wr_s;
  logic        resp_fire_s;

  // Decode, magnitude conversion and sign correction.
  always_comb begin
    acc_eff_s       = ACCURACY ? accuracy_level : 8'h00;
    mode_s          = sign_mode_of(funct3);
    mode_bits_s     = mode_s;
    neg_s           = (mode_bits_s[1] & rs1[31]) ^ (mode_bits_s[0] & rs2[31]);
    mag1_s          = magnitude(rs1, mode_bits_s[1]);
    mag2_s          = magnitude(rs2, mode_bits_s[0]);
    accept_s        = req_valid && !flush && is_legal_mul(opcode, funct3, funct7);
    fixed_product_s = neg_q ? (64'd0 - cres_q) : cres_q;
    fix_wr_s        = (state_q == FIX);
  end

  mul_product_cache #(
    .ENABLE(CACHE_EN)
  ) u_cache (
    .clk_i       (CLK),
    .rst_ni      (reset_n),
    .lk_rs1_i    (rs1),
    .lk_rs2_i    (rs2),
    .lk_acc_i    (acc_eff_s),
    .lk_mode_i   (mode_s),
    .lk_funct3_i (funct3),
    .hit_o       (cache_hit_s),
    .product_o   (cache_product_s),
    .wr_en_i     (fix_wr_s),
    .wr_rs1_i    (key_rs1_q),
    .wr_rs2_i    (key_rs2_q),
    .wr_acc_i    (key_acc_q),
    .wr_mode_i   (mode_q),
    .wr_product_i(fixed_product_s)
  );

  // A flush during the RESP cycle must still cancel the pulse, so the
  // registered pulse is gated and the held word only advances on a real pulse.
  assign resp_fire_s = resp_valid_q && !flush;

  // Sequencer FSM with registered core request and response.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      key_rs1_q       <= 32'd0;
      key_rs2_q       <= 32'd0;
      key_acc_q       <= 8'd0;
      mode_q          <= SM_UU;
      funct3_q        <= 3'd0;
      neg_q           <= 1'b0;
      cres_q          <= 64'd0;
      core_start_q    <= 1'b0;
      core_in_1_q     <= 32'd0;
      core_in_2_q     <= 32'd0;
      core_accuracy_q <= 8'd0;
      resp_valid_q    <= 1'b0;
      out_new_q       <= 32'd0;
      out_hold_q      <= 32'd0;
    end else begin
      core_start_q <= 1'b0;
      resp_valid_q <= 1'b0;
      if (resp_fire_s) begin
        out_hold_q <= out_new_q;
      end
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            key_rs1_q <= rs1;
            key_rs2_q <= rs2;
            key_acc_q <= acc_eff_s;
            mode_q    <= mode_s;
            funct3_q  <= funct3;
            neg_q     <= neg_s;
            if (cache_hit_s) begin
              out_new_q    <= select_word(cache_product_s, funct3);
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              core_in_1_q     <= mag1_s;
              core_in_2_q     <= mag2_s;
              core_accuracy_q <= acc_eff_s;
              core_start_q    <= 1'b1;
              state_q         <= ISSUE;
            end
          end
        end
        // core_busy may still be low while the core registers the start.
        ISSUE: state_q <= flush ? DRAIN : WAIT;
        WAIT: begin
          if (flush) begin
            state_q <= DRAIN;
          end else if (!core_busy) begin
            cres_q  <= core_result;
            state_q <= FIX;
          end
        end
        // The cache is written in this state regardless of flush.
        FIX: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            out_new_q    <= select_word(fixed_product_s, funct3_q);
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: state_q <= IDLE;
        DRAIN: begin
          if (!core_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign mul_unit_busy = (state_q != IDLE);
  assign resp_valid    = resp_fire_s;
  assign mul_output    = resp_fire_s ? out_new_q : out_hold_q;
  assign core_start    = core_start_q;
  assign core_in_1     = core_in_1_q;
  assign core_in_2     = core_in_2_q;
  assign core_accuracy = core_accuracy_q;

endmodule

// File: doc/multiplier_sequencer.md
Name: multiplier_sequencer

Overview:
- Sequences M-extension multiply ops (MUL/MULH/MULHSU/MULHU) onto an unsigned, multi-cycle, optionally approximate 32x32->64 multiplier core.
- Decodes the instruction and latches operands. Converts signed operands to magnitudes, then drives the core with a start/busy handshake.
- Applies sign correction and selects the low or high word. Raises the pipeline stall signal.
- Holds a one-entry product cache so that back-to-back MULH/MUL on identical operands completes without re-running the core.

Parameters:
- ACCURACY, 0: 1 = core is accuracy-controllable; 0 = core_accuracy is driven 8'h00 (never Z).
- CACHE_EN, 1: 1 = one-entry product cache enabled; 0 = every op issues to the core.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  decode stage presents an op this cycle.
- opcode  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- rs1  in  32  operand 1 (already forwarded).
- rs2  in  32  operand 2 (already forwarded).
- accuracy_level  in  8  accuracy value from CSR.
- flush  in  1  kill the in-flight op.
- req_ready  out  1  high only in IDLE.
- mul_unit_busy  out  1  stall; high whenever state != IDLE.
- resp_valid  out  1  one-cycle pulse; result is valid.
- mul_output  out  32  result; held until the next resp_valid.
- core_start  out  1  one-cycle start pulse to the core.
- core_in_1  out  32  magnitude of operand 1.
- core_in_2  out  32  magnitude of operand 2.
- core_accuracy  out  8  accuracy sent to the core.
- core_busy  in  1  core computing.
- core_result  in  64  unsigned product, valid when core_busy falls.

Behaviour:
- Reset values: state=IDLE; req_ready=1, mul_unit_busy=0, resp_valid=0, mul_output=0, core_start=0, core_in_*=0, core_accuracy=0; cache invalid.
- Decode:
  - An op is legal only when opcode=0110011, funct7=0000001 and funct3 is in 000..011.
  - A req_valid with an illegal decode is ignored: no state change, no response.
- Sign mode per op: MUL={s,s}, MULH={s,s}, MULHSU={s,u}, MULHU={u,u}.
- Accept: in IDLE with req_valid and a legal decode, latch rs1, rs2, funct3, accuracy and the sign mode.
  - neg = (a_signed & rs1[31]) XOR (b_signed & rs2[31]).
  - Magnitude = two's-complement negate when the signed bit is set; 0x80000000 maps to 0x80000000.
- Cache hit (CACHE_EN=1, cache valid):
  - Condition: rs1, rs2 and accuracy match the stored key, AND (the sign mode matches OR funct3=000).
  - The MUL low word is independent of signedness.
  - On hit: IDLE -> RESP. resp_valid is asserted the cycle after accept (latency 1). The core is not started.
- Miss path:
  - IDLE -> ISSUE. In ISSUE, core_start=1 for exactly one cycle with core_in_* and core_accuracy stable; core_in_* stay stable until the core returns.
  - ISSUE -> WAIT. core_busy is ignored in the ISSUE cycle. In WAIT, the first cycle with core_busy=0 captures core_result.
  - WAIT -> FIX. FIX computes p = neg ? -core_result : core_result (64-bit), writes the cache key and product, and sets cache valid.
  - FIX -> RESP.
  - Total latency = core cycles + 3.
- RESP: mul_output = (funct3=000) ? p[31:0] : p[63:32]. resp_valid=1 for one cycle, then IDLE.
- Flush:
  - In ISSUE or WAIT: go to DRAIN and wait for core_busy=0. The result is discarded; no resp_valid, no cache update. Then IDLE.
  - In FIX or RESP: the response is suppressed (resp_valid stays 0). The cache update in FIX still occurs. Next state is IDLE.
  - Flush in IDLE: no effect; a simultaneous req_valid is ignored.
- ACCURACY=0 forces core_accuracy=0, and accuracy is excluded from the cache key.
- Reset asserted mid-operation forces IDLE and invalidates the cache. Any core result arriving later is ignored.

Decomposition:
- Shared package mul_pkg holds:
  - OPCODE_OP=7'b0110011 and FUNCT7_MULDIV=7'b0000001.
  - funct3 constants F3_MUL/F3_MULH/F3_MULHSU/F3_MULHU.
  - The state enum IDLE/ISSUE/WAIT/FIX/RESP/DRAIN.
  - The sign-mode encoding.
- One natural sub-module: mul_product_cache (key compare, 64-bit product store, valid bit, invalidate on reset).

Test Plan:
- MUL 7 * -3, core latency 4 -> resp_valid 7 cycles after accept; mul_output=0xFFFFFFEB; core_in_1=7, core_in_2=3.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> mul_output=0xFFFFFFFE. Then MUL with the same operands -> cache hit, mul_output=0x00000001 one cycle after accept, no core_start.
- MULH 0x80000000 * 0x80000000 -> mul_output=0x40000000. MULHSU 0xFFFFFFFF(-1) * 0xFFFFFFFF -> mul_output=0xFFFFFFFF.
- Flush in WAIT with core latency 10 -> DRAIN until core_busy=0; no resp_valid; cache is not updated, so the next identical op issues core_start.
- Illegal op (funct7=0000000), then reset_n=0 during WAIT:
  - Illegal op: req_ready stays 1, no response.
  - Reset: all outputs return to reset values next cycle; the cache is invalid, so the repeated op misses.
- ACCURACY=1: two MULs with identical operands but accuracy 8'h10 vs 8'h20 -> both issue to the core; core_accuracy matches each value.
